// File: rtl/add_sub_pkg.sv
// Shared types and helpers for the sequential add/sub unit.
// Imported by add_sub_seq and its datapath slice.
package add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Chunk counter width; a single-chunk build still needs one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/add_sub_seq_chunk.sv
// CHUNK-bit adder slice with carry-in.
// Also exposes the carry into the slice MSB.
module chunk_add_sub #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] s_o,
  output logic             cout_o,
  output logic             cmsb_o
);

  logic [CHUNK:0] full;

  // Plain ripple sum; MSB carry-in recovered from the sum bit.
  always_comb begin
    full   = {1'b0, a_i} + {1'b0, b_i}
           + {{CHUNK{1'b0}}, cin_i};
    s_o    = full[CHUNK-1:0];
    cout_o = full[CHUNK];
    cmsb_o = s_o[CHUNK-1] ^ a_i[CHUNK-1]
           ^ b_i[CHUNK-1];
  end

endmodule

// File: rtl/add_sub_seq.sv
// Multi-cycle add/sub: CHUNK bits per clock, LS chunk first.
// Carry ripples between cycles through c_q.
module add_sub_seq
  import add_sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = cnt_w(NCHUNK);
  localparam logic [WIDTH-1:0] CMASK =
    WIDTH'({CHUNK{1'b1}});

  if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH ||
      (WIDTH % CHUNK) != 0) begin : g_bad_param
    $error("add_sub_seq: illegal WIDTH/CHUNK");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, res_d;
  logic             c_q, cout_q, ovf_q, zero_q;
  logic [31:0]      sh;
  logic [CHUNK-1:0] a_ch, b_ch, s_ch;
  logic             ch_cout, ch_cmsb;
  logic             last;

  chunk_add_sub #(.CHUNK(CHUNK)) u_chunk (
    .a_i   (a_ch),
    .b_i   (b_ch),
    .cin_i (c_q),
    .s_o   (s_ch),
    .cout_o(ch_cout),
    .cmsb_o(ch_cmsb)
  );

  // Select the active chunk and merge its sum into the word.
  always_comb begin
    sh    = 32'(cnt_q) * 32'(CHUNK);
    a_ch  = CHUNK'(a_q >> sh);
    b_ch  = CHUNK'(b_q >> sh);
    res_d = (res_q & ~(CMASK << sh))
          | (WIDTH'(s_ch) << sh);
    last  = (cnt_q == CW'(NCHUNK - 1));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid)  state_d = CALC;
      CALC: if (last)      state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the registered state.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Operand capture, per-chunk accumulate and final flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= 1'b0;
      cnt_q  <= '0;
      res_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b ^ {WIDTH{mode}};
            c_q   <= (mode == MODE_SUB);
            cnt_q <= '0;
          end
        end
        CALC: begin
          res_q <= res_d;
          c_q   <= ch_cout;
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            cout_q <= ch_cout;
            ovf_q  <= ch_cmsb ^ ch_cout;
            zero_q <= (res_d == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign result    = res_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_add_sub_seq.sv
// Bench for add_sub_seq over four WIDTH/CHUNK builds.
// Directed table, corner sequences and random ops vs a model.
module tb_add_sub_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int wid[4] = '{16, 16, 16, 8};
  int nch[4] = '{4, 1, 16, 4};

  logic        rstn[4], iv[4], md[4], ordy[4];
  logic [15:0] av[4], bv[4];
  logic        ir[4], ov[4], co[4], of[4], zr[4];
  logic [15:0] rs[4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int W = (g == 3) ? 8 : 16;
    localparam int C = (g == 0) ? 4 :
                       (g == 1) ? 16 :
                       (g == 2) ? 1 : 2;
    logic [W-1:0] res_w;
    add_sub_seq #(.WIDTH(W), .CHUNK(C)) u_dut (
      .clk      (clk),
      .rst_n    (rstn[g]),
      .in_valid (iv[g]),
      .in_ready (ir[g]),
      .a        (av[g][W-1:0]),
      .b        (bv[g][W-1:0]),
      .mode     (md[g]),
      .out_valid(ov[g]),
      .out_ready(ordy[g]),
      .result   (res_w),
      .carry_out(co[g]),
      .overflow (of[g]),
      .zero     (zr[g])
    );
    assign rs[g] = 16'(res_w);
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        m;
    logic [15:0] r;
    logic        c;
    logic        o;
    logic        z;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  // Reference: integer arithmetic on unsigned and signed views.
  task automatic model(input int w,
                       input logic [15:0] a,
                       input logic [15:0] b,
                       input logic m,
                       output logic [15:0] r,
                       output logic c,
                       output logic o,
                       output logic z);
    longint mod, half, ua, ub, u, sa, sb, s;
    mod  = 64'sd1 << w;
    half = mod / 2;
    ua = longint'(a) % mod;
    ub = longint'(b) % mod;
    if (m) begin
      u = ua - ub;
      c = (ua >= ub);
    end else begin
      u = ua + ub;
      c = (u >= mod);
    end
    if (u < 0) u = u + mod;
    r  = 16'(u % mod);
    sa = (ua >= half) ? ua - mod : ua;
    sb = (ub >= half) ? ub - mod : ub;
    s  = m ? sa - sb : sa + sb;
    o  = (s >= half) || (s < -half);
    z  = (r == 16'h0);
  endtask

  task automatic start(input int k,
                       input logic [15:0] a,
                       input logic [15:0] b,
                       input logic m);
    @(negedge clk);
    chk("in_ready_idle", 32'(ir[k]), 1);
    iv[k] = 1'b1;
    av[k] = a;
    bv[k] = b;
    md[k] = m;
    @(negedge clk);
    iv[k] = 1'b0;
  endtask

  task automatic wait_out(input int k, output int n);
    n = 0;
    while (n < 64) begin
      if (ov[k]) break;
      chk("in_ready_busy", 32'(ir[k]), 0);
      @(negedge clk);
      n++;
    end
  endtask

  task automatic op_check(input int k,
                          input logic [15:0] a,
                          input logic [15:0] b,
                          input logic m,
                          input logic [15:0] r,
                          input logic c,
                          input logic o,
                          input logic z);
    int n;
    start(k, a, b, m);
    wait_out(k, n);
    chk("latency", n, nch[k]);
    chk("result", 32'(rs[k]), 32'(r));
    chk("carry", 32'(co[k]), 32'(c));
    chk("overflow", 32'(of[k]), 32'(o));
    chk("zero", 32'(zr[k]), 32'(z));
    @(negedge clk);
    chk("valid_drop", 32'(ov[k]), 0);
    chk("ready_back", 32'(ir[k]), 1);
  endtask

  initial begin
    int n;
    logic [15:0] ra, rb, er;
    logic rm, ec, eo, ez;

    vt[0] = '{16'h1234, 16'h0FCD, 1'b0, 16'h2201, 0, 0, 0};
    vt[1] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1, 1, 0};
    vt[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 0, 1, 0};
    vt[3] = '{16'h0005, 16'h0005, 1'b1, 16'h0000, 1, 0, 1};
    vt[4] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1, 0, 1};
    vt[5] = '{16'h0003, 16'h0005, 1'b1, 16'hFFFE, 0, 0, 0};

    for (int k = 0; k < 4; k++) begin
      rstn[k] = 1'b0;
      iv[k]   = 1'b0;
      md[k]   = 1'b0;
      ordy[k] = 1'b1;
      av[k]   = '0;
      bv[k]   = '0;
    end
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk("rst_in_ready", 32'(ir[k]), 1);
      chk("rst_out_valid", 32'(ov[k]), 0);
      chk("rst_result", 32'(rs[k]), 0);
      chk("rst_flags", {29'd0, co[k], of[k], zr[k]}, 0);
      rstn[k] = 1'b1;
    end

    for (int i = 0; i < 6; i++)
      op_check(0, vt[i].a, vt[i].b, vt[i].m,
               vt[i].r, vt[i].c, vt[i].o, vt[i].z);

    // Backpressure: held result while in_valid toggles.
    ordy[0] = 1'b0;
    start(0, 16'h1111, 16'h2222, 1'b0);
    wait_out(0, n);
    chk("bp_latency", n, 4);
    for (int i = 0; i < 6; i++) begin
      chk("bp_valid", 32'(ov[0]), 1);
      chk("bp_in_ready", 32'(ir[0]), 0);
      chk("bp_result", 32'(rs[0]), 32'h3333);
      chk("bp_flags", {29'd0, co[0], of[0], zr[0]}, 0);
      iv[0] = ~iv[0];
      av[0] = 16'($urandom);
      bv[0] = 16'($urandom);
      md[0] = 1'($urandom);
      @(negedge clk);
    end
    iv[0]   = 1'b0;
    ordy[0] = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 32'(ov[0]), 0);
    chk("bp_release_ready", 32'(ir[0]), 1);
    chk("bp_no_accept", 32'(rs[0]), 32'h3333);

    // Asynchronous reset in the second CALC cycle.
    start(0, 16'hABCD, 16'h1357, 1'b0);
    @(negedge clk);
    #2 rstn[0] = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(ov[0]), 0);
    chk("mid_rst_result", 32'(rs[0]), 0);
    chk("mid_rst_flags", {29'd0, co[0], of[0], zr[0]}, 0);
    chk("mid_rst_ready", 32'(ir[0]), 1);
    @(negedge clk);
    rstn[0] = 1'b1;
    op_check(0, 16'h00FF, 16'h0001, 1'b0,
             16'h0100, 1'b0, 1'b0, 1'b0);

    // Random ops on every build.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 30; i++) begin
        ra = 16'($urandom);
        rb = 16'($urandom);
        rm = 1'($urandom);
        if (i == 0) rb = ra;
        model(wid[k], ra, rb, rm, er, ec, eo, ez);
        op_check(k, ra, rb, rm, er, ec, eo, ez);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
